// File: rtl/typedefs.sv
// Shared retirement types: ROB entry layout, committed-store entry and drain FSM states.
// The optional performance counters in retire_commit are enabled by RETIRE_PERF_CNT_EN.
package typedefs;

    localparam int XLEN   = 32;
    localparam int PREG_W = 6;

    typedef struct packed {
        logic RegWrite;
        logic MemWrite;
    } controlStruct;

    typedef struct packed {
        logic              valid;
        logic              complete;
        controlStruct      control;
        logic [PREG_W-1:0] rd_old;
        logic [XLEN-1:0]   result;
        logic [XLEN-1:0]   mem_data;
    } robEntryStruct;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
    } sqEntryStruct;

    typedef enum logic [0:0] {
        DR_IDLE = 1'b0,
        DR_REQ  = 1'b1
    } drainStateEnum;

    // A store's address is the ALU result; its payload travels in mem_data.
    function automatic sqEntryStruct sq_entry(input robEntryStruct e);
        sqEntryStruct s;
        s.addr = e.result;
        s.data = e.mem_data;
        return s;
    endfunction

endpackage

// File: rtl/store_queue.sv
// Committed-store circular buffer: up to two pushes (lane 1 first) and one pop per cycle,
// with a credit flag that guarantees room for a worst-case two-store retire.
module store_queue
    import typedefs::*;
#(
    parameter int SQ_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push1_i,
    input  logic                         push2_i,
    input  sqEntryStruct                 entry1_i,
    input  sqEntryStruct                 entry2_i,
    input  logic                         pop_i,
    output sqEntryStruct                 head_o,
    output logic [$clog2(SQ_DEPTH):0]    count_next_o,
    output logic                         credit_o
);

    localparam int PTR_W = $clog2(SQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(SQ_DEPTH - 2);

    sqEntryStruct     mem_q [SQ_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] tail_p1;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       n_push;
    logic             wr_a_en, wr_b_en;
    sqEntryStruct     wr_a, wr_b;

    // A lone lane-2 store lands in the tail slot, exactly like a lone lane-1 store.
    always_comb begin
        n_push  = {1'b0, push1_i} + {1'b0, push2_i};
        tail_p1 = tail_q + PTR_W'(1);
        wr_a_en = push1_i | push2_i;
        wr_a    = push1_i ? entry1_i : entry2_i;
        wr_b_en = push1_i & push2_i;
        wr_b    = entry2_i;
        tail_d  = tail_q + PTR_W'(n_push);
        head_d  = head_q + PTR_W'(pop_i);
        count_d = count_q + CNT_W'(n_push) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_a_en) mem_q[tail_q]  <= wr_a;
        if (wr_b_en) mem_q[tail_p1] <= wr_b;
    end

    assign head_o       = mem_q[head_q];
    assign count_next_o = count_d;
    assign credit_o     = (count_q <= CREDIT_MAX);

endmodule

// File: rtl/retire_commit.sv
// Two-wide in-order retirement: frees stale physical registers and drains committed stores.
// Define RETIRE_PERF_CNT_EN to build the retired/store performance counters.
module retire_commit
    import typedefs::*;
#(
    parameter int SQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  robEntryStruct     rob_in1,
    input  robEntryStruct     rob_in2,
    output logic              in_ready,
    output logic              free_valid1,
    output logic              free_valid2,
    output logic [PREG_W-1:0] free_reg1,
    output logic [PREG_W-1:0] free_reg2,
    output logic              mem_wr_valid,
    output logic [XLEN-1:0]   mem_wr_addr,
    output logic [XLEN-1:0]   mem_wr_data,
    input  logic              mem_wr_ready,
    output logic [31:0]       retired_count,
    output logic [31:0]       store_count
);

    localparam int CNT_W = $clog2(SQ_DEPTH) + 1;

    logic              ret1, ret2;
    logic              push1, push2, pop;
    logic              free1_d, free2_d;
    logic [PREG_W-1:0] freg1_d, freg2_d;
    logic              free1_q, free2_q;
    logic [PREG_W-1:0] freg1_q, freg2_q;
    logic [CNT_W-1:0]  sq_count_next;
    sqEntryStruct      head;
    drainStateEnum     state_q, state_d;

    // Lane 2 is gated by lane 1 so retirement never skips an older entry.
    always_comb begin
        ret1    = in_ready & rob_in1.valid & rob_in1.complete;
        ret2    = ret1 & rob_in2.valid & rob_in2.complete;
        free1_d = ret1 & rob_in1.control.RegWrite & (rob_in1.rd_old != '0);
        free2_d = ret2 & rob_in2.control.RegWrite & (rob_in2.rd_old != '0);
        freg1_d = free1_d ? rob_in1.rd_old : '0;
        freg2_d = free2_d ? rob_in2.rd_old : '0;
        push1   = ret1 & rob_in1.control.MemWrite;
        push2   = ret2 & rob_in2.control.MemWrite;
        pop     = mem_wr_valid & mem_wr_ready;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            free1_q <= 1'b0;
            free2_q <= 1'b0;
            freg1_q <= '0;
            freg2_q <= '0;
        end else begin
            free1_q <= free1_d;
            free2_q <= free2_d;
            freg1_q <= freg1_d;
            freg2_q <= freg2_d;
        end
    end

    assign free_valid1 = free1_q;
    assign free_valid2 = free2_q;
    assign free_reg1   = freg1_q;
    assign free_reg2   = freg2_q;

    store_queue #(
        .SQ_DEPTH (SQ_DEPTH)
    ) u_sq (
        .clk          (clk),
        .reset        (reset),
        .push1_i      (push1),
        .push2_i      (push2),
        .entry1_i     (sq_entry(rob_in1)),
        .entry2_i     (sq_entry(rob_in2)),
        .pop_i        (pop),
        .head_o       (head),
        .count_next_o (sq_count_next),
        .credit_o     (in_ready)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= DR_IDLE;
        else        state_q <= state_d;
    end

    // Decisions use the post-update count so a fresh store requests the very next cycle
    // and a store pushed during the final pop keeps the request alive.
    always_comb begin
        state_d      = state_q;
        mem_wr_valid = 1'b0;
        mem_wr_addr  = '0;
        mem_wr_data  = '0;
        case (state_q)
            DR_IDLE: begin
                if (sq_count_next != '0) state_d = DR_REQ;
            end
            DR_REQ: begin
                mem_wr_valid = 1'b1;
                mem_wr_addr  = head.addr;
                mem_wr_data  = head.data;
                if (mem_wr_ready && (sq_count_next == '0)) state_d = DR_IDLE;
            end
            default: state_d = DR_IDLE;
        endcase
    end

`ifdef RETIRE_PERF_CNT_EN
    logic [31:0] retired_q, stores_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_q <= '0;
            stores_q  <= '0;
        end else begin
            retired_q <= retired_q + 32'(ret1) + 32'(ret2);
            stores_q  <= stores_q + 32'(pop);
        end
    end

    assign retired_count = retired_q;
    assign store_count   = stores_q;
`else
    assign retired_count = '0;
    assign store_count   = '0;
`endif

endmodule
